// File: rtl/spi_tx_arbiter_if.sv
// Requester-side bus of the SPI transmit arbiter: per-requester byte
// handshake plus the per-requester completion pulse.
interface spi_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_done;

    // Client logic side
    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, req_done
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, req_done
    );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Shares one 8-bit SPI transmitter among NUM_REQ requesters. Bursts are
// granted round-robin and locked until the byte flagged last completes.
// A watchdog aborts a stalled core (WAIT) or an abandoned burst (HOLD).
module spi_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    spi_tx_arbiter_if.slave            bus,
    input  logic                       err_clear,
    output logic [DATA_W-1:0]          spi_data_in,
    output logic                       spi_load_data,
    input  logic                       spi_done_send,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       timeout_err
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] last_grant, winner, sel, idx;
    logic [TMR_W-1:0] timer;
    logic            any_valid, last_flag, accept;
    logic            tmr_max, done_hit, timeout_hit;

    assign tmr_max     = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    // The core's done pulse only counts while a byte is actually in flight.
    assign done_hit    = (state == WAIT) && spi_done_send;
    // An owner presenting a byte in HOLD wins over the watchdog.
    assign timeout_hit = tmr_max &&
                         (((state == WAIT) && !spi_done_send) ||
                          ((state == HOLD) && !bus.req_valid[active_id]));
    assign accept      = |bus.req_ready;

    // Round-robin search: first valid index after last_grant, wrapping.
    // Scanning downward lets the nearest candidate overwrite the rest.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_valid) state_nxt = LOAD;
            LOAD: state_nxt = WAIT;
            WAIT: begin
                if (done_hit)         state_nxt = last_flag ? IDLE : HOLD;
                else if (timeout_hit) state_nxt = IDLE;
            end
            HOLD: begin
                if (bus.req_valid[active_id]) state_nxt = LOAD;
                else if (timeout_hit)         state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs: at most one ready bit, only in IDLE or HOLD
    always_comb begin
        bus.req_ready = '0;
        busy          = (state != IDLE);
        sel           = winner;
        case (state)
            IDLE: if (any_valid) bus.req_ready[winner] = 1'b1;
            HOLD: begin
                sel = active_id;
                if (bus.req_valid[active_id]) bus.req_ready[active_id] = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: byte capture, load strobe, done pulse, timer and error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            spi_data_in   <= '0;
            spi_load_data <= 1'b0;
            bus.req_done  <= '0;
            active_id     <= '0;
            last_flag     <= 1'b0;
            last_grant    <= ID_W'(NUM_REQ - 1);
            timer         <= '0;
            timeout_err   <= 1'b0;
        end else begin
            spi_load_data <= accept;
            bus.req_done  <= '0;
            if (accept) begin
                spi_data_in <= bus.req_data[int'(sel)*DATA_W +: DATA_W];
                active_id   <= sel;
                last_flag   <= bus.req_last[sel];
            end
            if (done_hit) begin
                bus.req_done[active_id] <= 1'b1;
                if (last_flag) last_grant <= active_id;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
                last_grant  <= active_id;
            end else if (err_clear) begin
                timeout_err <= 1'b0;
            end
            // Timer runs only while waiting on the core or on the owner.
            if ((state == WAIT && !spi_done_send) || state == HOLD) begin
                if (!tmr_max) timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level arbitration model.
module tb_spi_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          err_clear = 1'b0;
    logic [DW-1:0] spi_data_in;
    logic          spi_load_data;
    logic          spi_done_send = 1'b0;
    logic          busy;
    logic [1:0]    active_id;
    logic          timeout_err;

    always #5 clock = ~clock;

    spi_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    spi_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .err_clear    (err_clear),
        .spi_data_in  (spi_data_in),
        .spi_load_data(spi_load_data),
        .spi_done_send(spi_done_send),
        .busy         (busy),
        .active_id    (active_id),
        .timeout_err  (timeout_err)
    );

    int total = 0;
    int bad   = 0;

    // Per-requester byte queues: bit 8 = last flag
    logic [8:0] fifo [NR][256];
    int         hd [NR];
    int         tl [NR];

    // Model: what the arbiter should be doing, in transaction terms
    bit         m_load;      // a byte was accepted; load strobe expected now
    bit         m_out;       // byte handed to core, awaiting done
    bit         m_last;      // in-flight byte ends its burst
    bit         m_err;
    int         m_owner;     // burst owner, -1 when no burst open
    int         m_rr;        // most recent completed/aborted grant
    int         m_age;       // cycles spent waiting on core or owner
    int         m_done_due;  // requester expecting a done pulse now
    int         m_id;
    logic [7:0] m_data;

    // Stimulus knobs
    logic [NR-1:0] gate = '1;
    int            done_delay = 3;
    bit            spur = 0, load_spur = 0, force_done = 0, clr = 0, rnd_mode = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit last);
        fifo[i][tl[i] % 256] = {last, d};
        tl[i]++;
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++)
            if (v[(m_rr + k) % NR]) return (m_rr + k) % NR;
        return -1;
    endfunction

    task automatic model_reset();
        m_load = 0; m_out = 0; m_last = 0; m_err = 0;
        m_owner = -1; m_rr = NR - 1; m_age = 0; m_done_due = -1;
        m_id = 0; m_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
        spi_done_send = 1'b0; err_clear = 1'b0;
        for (int i = 0; i < NR; i++) hd[i] = tl[i];
        @(negedge clock);
        model_reset();
        chk("rst_load", 32'(spi_load_data), 32'd0);
        chk("rst_data", 32'(spi_data_in), 32'd0);
        chk("rst_done", 32'(bus.req_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(active_id), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
    endtask

    // One clock: check registered outputs, drive inputs, check ready,
    // then advance the model across the coming edge.
    task automatic step();
        logic [NR-1:0] v;
        logic [8:0]    fr;
        int            g;
        bit            set_now;
        @(negedge clock);
        chk("load", 32'(spi_load_data), 32'(m_load));
        if (m_load) chk("data", 32'(spi_data_in), 32'(m_data));
        chk("done", 32'(bus.req_done), (m_done_due >= 0) ? (32'd1 << m_done_due) : 32'd0);
        chk("busy", 32'(busy), 32'(m_load || m_out || (m_owner >= 0)));
        chk("id", 32'(active_id), 32'(m_id));
        chk("err", 32'(timeout_err), 32'(m_err));

        for (int i = 0; i < NR; i++) begin
            v[i] = (tl[i] > hd[i]) && gate[i];
            fr = (tl[i] > hd[i]) ? fifo[i][hd[i] % 256] : 9'h0;
            bus.req_valid[i] = v[i];
            bus.req_data[i*DW +: DW] = fr[7:0];
            bus.req_last[i] = fr[8];
        end
        spi_done_send = (m_out && m_age == done_delay) || force_done ||
                        (load_spur && m_load) || (spur && $urandom_range(0, 3) == 0);
        err_clear = clr;
        #1;
        g = -1;
        if (!m_load && !m_out) begin
            if (m_owner >= 0) g = v[m_owner] ? m_owner : -1;
            else              g = rr_pick(v);
        end
        chk("ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);

        m_done_due = -1;
        set_now = 0;
        if (m_load) begin
            m_load = 0; m_out = 1; m_age = 0;
        end else if (m_out) begin
            if (spi_done_send) begin
                m_done_due = m_id; m_out = 0; m_age = 0;
                if (m_last) begin m_rr = m_id; m_owner = -1; end
            end else if (m_age == TO - 1) begin
                set_now = 1; m_out = 0; m_rr = m_id; m_owner = -1;
            end else begin
                m_age++;
            end
        end else if (g >= 0) begin
            fr = fifo[g][hd[g] % 256];
            hd[g]++;
            m_data = fr[7:0]; m_last = fr[8]; m_id = g; m_owner = g; m_load = 1;
            if (rnd_mode)
                done_delay = ($urandom_range(0, 15) == 0) ? 40 : $urandom_range(0, 6);
        end else if (m_owner >= 0) begin
            if (m_age == TO - 1) begin
                set_now = 1; m_rr = m_owner; m_owner = -1;
            end else begin
                m_age++;
            end
        end
        if (set_now)  m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin hd[i] = 0; tl[i] = 0; end
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
        model_reset();
        do_reset();

        // Single byte with a slow core
        done_delay = 10;
        push(0, 8'hA5, 1);
        run(20);

        // Round robin over single-byte bursts
        do_reset();
        done_delay = 2;
        push(0, 8'h10, 1); push(1, 8'h11, 1); push(2, 8'h12, 1); push(3, 8'h13, 1);
        push(0, 8'h10, 1);
        run(40);

        // Burst lock: requester 2 waits out requester 1's burst
        do_reset();
        push(1, 8'h01, 0); push(1, 8'h02, 0); push(1, 8'h03, 1);
        push(2, 8'h20, 1);
        run(40);

        // Watchdog in WAIT, then clear the flag
        done_delay = 100;
        push(0, 8'h55, 1);
        run(22);
        clr = 1; run(1); clr = 0; run(3);

        // Abandoned burst times out in HOLD; clear held across the set
        done_delay = 2;
        push(3, 8'h77, 0);
        clr = 1;
        run(28);
        clr = 0;

        // Done during the load cycle is ignored
        load_spur = 1; done_delay = 5;
        push(2, 8'h3C, 1);
        run(15);
        load_spur = 0;

        // Reset while waiting on the core, then a stray done
        done_delay = 100;
        push(1, 8'h99, 1);
        run(5);
        do_reset();
        force_done = 1; step(); force_done = 0;
        done_delay = 1;
        push(3, 8'hC3, 1); push(2, 8'hC2, 1); push(1, 8'hC1, 1); push(0, 8'hC0, 1);
        run(30);

        // Randomized traffic
        rnd_mode = 1; spur = 1;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NR; i++) begin
                gate[i] = ($urandom_range(0, 3) != 0);
                if ((tl[i] - hd[i]) < 20 && $urandom_range(0, 15) == 0) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++)
                        push(i, 8'($urandom), (b == len - 1));
                end
            end
            clr = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares the single 8-bit SPI transmitter core among NUM_REQ requesters.
- Round-robin arbitration per burst; a granted requester keeps the transmitter until it marks a byte as last.
- Sequences the core's load/done handshake.
- Watchdog timer recovers from a stalled core or an abandoned burst.
- Sits between the client logic and the transmitter core, in the same clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; matches transmitter data input.
- TIMEOUT_CYCLES, 4096, clock cycles allowed in WAIT or HOLD before abort.

Ports:
- clock  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  byte is final of burst; qualified by req_valid.
- req_ready  out  NUM_REQ  combinational accept; transfer when valid&ready.
- req_done  out  NUM_REQ  1-cycle pulse: requester's byte fully shifted out.
- err_clear  in  1  clears timeout_err.
- spi_data_in  out  DATA_W  byte to transmitter; registered.
- spi_load_data  out  1  1-cycle load strobe to transmitter; registered.
- spi_done_send  in  1  transmitter done pulse.
- busy  out  1  high in any state other than IDLE.
- active_id  out  clog2(NUM_REQ)  current/last granted requester.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (synchronous, any state):
  - state=IDLE; all outputs 0; active_id=0; timer=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
  - A reset mid-transfer drops the burst; no req_done is issued.
- States: IDLE, LOAD, WAIT, HOLD.
- IDLE:
  - If any req_valid: winner = first valid index searching from last_grant+1 upward, modulo NUM_REQ.
  - req_ready[winner]=1 this cycle, combinational; all other ready bits 0.
  - Registers: spi_data_in<=req_data[winner], active_id<=winner, last_flag<=req_last[winner], spi_load_data<=1.
  - Next state LOAD.
- LOAD (exactly 1 cycle): spi_load_data high; timer cleared; spi_done_send ignored; -> WAIT.
- WAIT:
  - spi_load_data=0; spi_data_in held stable; timer increments.
  - On spi_done_send: req_done[active_id] pulses the next cycle; timer cleared.
    - If last_flag: last_grant<=active_id, -> IDLE.
    - Else -> HOLD.
  - If timer reaches TIMEOUT_CYCLES-1 without done: timeout_err<=1, no req_done, last_grant<=active_id, -> IDLE.
- HOLD (burst lock):
  - Only active_id may transfer. If req_valid[active_id]: req_ready[active_id]=1, load byte and last flag as in IDLE, -> LOAD.
  - Other requesters get ready=0 regardless of valid.
  - Timer increments; at TIMEOUT_CYCLES-1: timeout_err<=1, last_grant<=active_id, -> IDLE (burst abandoned).
- Ready is never asserted in LOAD or WAIT. At most one ready bit is high at any time.
- Back-to-back: minimum gap from done to next load is 2 cycles (done, then IDLE/HOLD accept, then load).
- timeout_err: set has priority over err_clear in the same cycle. Otherwise err_clear clears it. Arbitration continues while it is set.
- Timer width: clog2(TIMEOUT_CYCLES); saturates, never wraps.
- spi_done_send outside WAIT: ignored.
- Round-robin fairness: with all requesters continuously valid and single-byte bursts, grant order is 0,1,2,3,0,...
- busy = (state != IDLE).

Test Plan:
- Single byte:
  - Stimulus: req_valid[0]=1, req_data=0xA5, last=1 at cycle t.
  - Response: req_ready[0] at t; spi_load_data=1 with spi_data_in=0xA5 at t+1. Inject done 20 cycles later -> req_done[0] one cycle after done; busy drops.
- Round robin:
  - Stimulus: all 4 valid with single-byte bursts 0x10,0x11,0x12,0x13; done returned each time.
  - Response: spi_data_in sequence 0x10,0x11,0x12,0x13,0x10; active_id follows 0,1,2,3,0.
- Burst lock:
  - Stimulus: requester 1 sends 0x01,0x02,0x03 (last on 0x03) while requester 2 holds valid.
  - Response: all three bytes from requester 1 issue consecutively; req_ready[2] stays 0 until after the done for 0x03; then requester 2 is granted.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16; withhold spi_done_send after a load.
  - Response: timeout_err=1 at cycle 16 of WAIT, no req_done, back to IDLE. Assert err_clear -> flag 0.
- Reset mid-WAIT:
  - Stimulus: assert reset during WAIT.
  - Response: next cycle all outputs 0, state IDLE, requester 0 has priority; a stray done pulse after reset produces no req_done.
- Spurious done:
  - Stimulus: spi_done_send high during the LOAD cycle.
  - Response: ignored; block stays in WAIT until a genuine done arrives.
